// File: rtl/bias_pe_collector.sv
// rtl/bias_pe_collector.sv - bias bank owner and result collector for the bias PE
//
// Holds the per-neuron bias bank, presents bank[idx] to the PE as init_bias,
// accepts {net_sum, bias_change} results, forwards net_sum downstream and, in
// training passes, writes bias_change back into the bank. One pass over all
// neurons per start.
//
// Ports:
//   ap_clk, ap_rst_n, ap_ce     clock, async active-low reset, clock enable
//   start, training             pass request (IDLE only), training mode flag
//   in_valid/in_ready           PE result handshake
//   in_net_sum, in_bias_change  PE result pair
//   bias_out, idx_out           init_bias operand and current neuron index
//   out_valid/out_ready         downstream handshake
//   out_net_sum, out_idx        forwarded result and its neuron index
//   cfg_we, cfg_addr, cfg_wdata bank configuration writes (IDLE only)
//   busy, frame_done            pass in progress, end-of-pass pulse

module bias_pe_collector #(
    parameter int N_NEURONS = 8,
    parameter int DW        = 16,
    parameter int IW        = $clog2(N_NEURONS)
) (
    input  logic          ap_clk,
    input  logic          ap_rst_n,
    input  logic          ap_ce,
    input  logic          start,
    input  logic          training,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_net_sum,
    input  logic [DW-1:0] in_bias_change,
    output logic [DW-1:0] bias_out,
    output logic [IW-1:0] idx_out,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_net_sum,
    output logic [IW-1:0] out_idx,
    input  logic          cfg_we,
    input  logic [IW-1:0] cfg_addr,
    input  logic [DW-1:0] cfg_wdata,
    output logic          busy,
    output logic          frame_done
);

    localparam logic [IW-1:0] LP_LAST  = IW'(N_NEURONS - 1);
    localparam logic [IW:0]   LP_DEPTH = (IW + 1)'(N_NEURONS);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic          w_frame_done_nxt;

    logic [DW-1:0] r_bank [N_NEURONS];
    logic [IW-1:0] r_idx;
    logic          r_training_q;
    logic          r_out_valid;
    logic [DW-1:0] r_out_net_sum;
    logic [IW-1:0] r_out_idx;
    logic          r_frame_done;

    logic          w_in_ready;
    logic          w_accept;
    logic          w_last;
    logic          w_start;
    logic          w_cfg_wr;
    logic          w_train_wr;

    // in_ready looks through the output register to out_ready so a result
    // can be accepted in the same cycle the previous one leaves.
    assign w_in_ready = (r_state == S_RUN) && (!r_out_valid || out_ready);
    assign w_accept   = ap_ce && in_valid && w_in_ready;
    assign w_last     = (r_idx == LP_LAST);
    assign w_start    = (r_state == S_IDLE) && start;
    assign w_cfg_wr   = ap_ce && (r_state == S_IDLE) && cfg_we &&
                        ({1'b0, cfg_addr} < LP_DEPTH);
    assign w_train_wr = w_accept && r_training_q;

    // Next-state logic
    always_comb begin
        w_state_nxt      = r_state;
        w_frame_done_nxt = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                if (w_accept && w_last) begin
                    w_state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: begin
                // Finish once the last forwarded result has left (or leaves now).
                if (!r_out_valid || out_ready) begin
                    w_state_nxt      = S_IDLE;
                    w_frame_done_nxt = 1'b1;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // State register and end-of-pass pulse
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            r_state      <= S_IDLE;
            r_frame_done <= 1'b0;
        end else if (ap_ce) begin
            r_state      <= w_state_nxt;
            r_frame_done <= w_frame_done_nxt;
        end
    end

    // Neuron index and latched training mode
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            r_idx        <= '0;
            r_training_q <= 1'b0;
        end else if (ap_ce) begin
            if (w_start) begin
                r_idx        <= '0;
                r_training_q <= training;
            end else if (w_accept) begin
                r_idx <= w_last ? '0 : r_idx + 1'b1;
            end
        end
    end

    // Forwarding register toward the activation stage
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            r_out_valid   <= 1'b0;
            r_out_net_sum <= '0;
            r_out_idx     <= '0;
        end else if (ap_ce) begin
            if (w_accept) begin
                r_out_valid   <= 1'b1;
                r_out_net_sum <= in_net_sum;
                r_out_idx     <= r_idx;
            end else if (out_ready) begin
                r_out_valid   <= 1'b0;
            end
        end
    end

    // Bias bank: configured in IDLE, updated by training write-back in RUN.
    // The two writers live in disjoint states, so they never collide.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            for (int k = 0; k < N_NEURONS; k++) begin
                r_bank[k] <= '0;
            end
        end else if (w_train_wr) begin
            r_bank[r_idx] <= in_bias_change;
        end else if (w_cfg_wr) begin
            r_bank[cfg_addr] <= cfg_wdata;
        end
    end

    assign in_ready    = w_in_ready;
    assign bias_out    = r_bank[r_idx];
    assign idx_out     = r_idx;
    assign out_valid   = r_out_valid;
    assign out_net_sum = r_out_net_sum;
    assign out_idx     = r_out_idx;
    assign busy        = (r_state != S_IDLE);
    assign frame_done  = r_frame_done;

endmodule

// File: tb/tb_bias_pe_collector.sv
// tb/tb_bias_pe_collector.sv - directed self-checking bench for bias_pe_collector

module tb_bias_pe_collector;

    localparam int N  = 8;
    localparam int DW = 16;
    localparam int IW = 3;

    logic          ap_clk = 1'b0;
    logic          ap_rst_n;
    logic          ap_ce;
    logic          start;
    logic          training;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_net_sum;
    logic [DW-1:0] in_bias_change;
    logic [DW-1:0] bias_out;
    logic [IW-1:0] idx_out;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_net_sum;
    logic [IW-1:0] out_idx;
    logic          cfg_we;
    logic [IW-1:0] cfg_addr;
    logic [DW-1:0] cfg_wdata;
    logic          busy;
    logic          frame_done;

    int n_cmp = 0;
    int n_err = 0;

    logic [DW-1:0] exp_bank [N];

    bias_pe_collector #(.N_NEURONS(N), .DW(DW), .IW(IW)) dut (
        .ap_clk         (ap_clk),
        .ap_rst_n       (ap_rst_n),
        .ap_ce          (ap_ce),
        .start          (start),
        .training       (training),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_net_sum     (in_net_sum),
        .in_bias_change (in_bias_change),
        .bias_out       (bias_out),
        .idx_out        (idx_out),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_net_sum    (out_net_sum),
        .out_idx        (out_idx),
        .cfg_we         (cfg_we),
        .cfg_addr       (cfg_addr),
        .cfg_wdata      (cfg_wdata),
        .busy           (busy),
        .frame_done     (frame_done)
    );

    always #5 ap_clk = ~ap_clk;

    task automatic tick();
        @(posedge ap_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One pass. bp_at: index after whose accept out_ready is held low for 3
    // cycles. poke_at: index at which start/cfg_we are pulsed. ce_at: index at
    // which ap_ce drops for 3 cycles (also freezes the frame_done pulse).
    task automatic run_pass(input bit trn, input int ns_base, input int bc_base,
                            input int bp_at, input int poke_at, input int ce_at);
        start    = 1'b1;
        training = trn;
        tick();
        start    = 1'b0;
        training = 1'b0;
        chk("busy_after_start", 32'(busy), 32'd1);
        for (int i = 0; i < N; i++) begin
            in_valid       = 1'b1;
            in_net_sum     = 16'(ns_base + i);
            in_bias_change = 16'(bc_base - i);
            out_ready      = 1'b1;
            if (i == poke_at) begin
                start     = 1'b1;
                cfg_we    = 1'b1;
                cfg_addr  = 3'd2;
                cfg_wdata = 16'h7FFF;
            end
            #1;
            chk("bias_out", 32'(bias_out), 32'(exp_bank[i]));
            chk("idx_out", 32'(idx_out), 32'(i));
            chk("in_ready_run", 32'(in_ready), 32'd1);
            if (i == ce_at) begin
                ap_ce = 1'b0;
                repeat (3) tick();
                chk("ce_idx_frozen", 32'(idx_out), 32'(i));
                chk("ce_out_idx_frozen", 32'(out_idx), 32'(i - 1));
                chk("ce_out_ns_frozen", 32'(out_net_sum), 32'(16'(ns_base + i - 1)));
                ap_ce = 1'b1;
            end
            tick();
            start  = 1'b0;
            cfg_we = 1'b0;
            if (trn) exp_bank[i] = 16'(bc_base - i);
            chk("out_valid", 32'(out_valid), 32'd1);
            chk("out_net_sum", 32'(out_net_sum), 32'(16'(ns_base + i)));
            chk("out_idx", 32'(out_idx), 32'(i));
            chk("busy_run", 32'(busy), 32'd1);
            if (i == bp_at) begin
                out_ready  = 1'b0;
                in_net_sum = 16'(ns_base + i + 1);
                #1;
                repeat (3) begin
                    chk("bp_in_ready", 32'(in_ready), 32'd0);
                    tick();
                    chk("bp_out_ns_hold", 32'(out_net_sum), 32'(16'(ns_base + i)));
                    chk("bp_out_idx_hold", 32'(out_idx), 32'(i));
                    chk("bp_out_valid_hold", 32'(out_valid), 32'd1);
                    chk("bp_idx_hold", 32'(idx_out), 32'(i + 1));
                end
            end
        end
        in_valid = 1'b0;
        #1;
        chk("drain_in_ready", 32'(in_ready), 32'd0);
        chk("drain_no_done", 32'(frame_done), 32'd0);
        chk("drain_busy", 32'(busy), 32'd1);
        tick();
        chk("frame_done", 32'(frame_done), 32'd1);
        chk("idle_busy", 32'(busy), 32'd0);
        chk("idle_out_valid", 32'(out_valid), 32'd0);
        if (ce_at >= 0) begin
            ap_ce = 1'b0;
            repeat (2) tick();
            chk("ce_done_frozen", 32'(frame_done), 32'd1);
            ap_ce = 1'b1;
        end
        tick();
        chk("frame_done_pulse", 32'(frame_done), 32'd0);
    endtask

    initial begin
        ap_rst_n       = 1'b0;
        ap_ce          = 1'b1;
        start          = 1'b0;
        training       = 1'b0;
        in_valid       = 1'b0;
        in_net_sum     = '0;
        in_bias_change = '0;
        out_ready      = 1'b1;
        cfg_we         = 1'b0;
        cfg_addr       = '0;
        cfg_wdata      = '0;
        repeat (2) tick();

        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_bias_out", 32'(bias_out), 32'd0);
        chk("rst_idx_out", 32'(idx_out), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_net_sum", 32'(out_net_sum), 32'd0);
        chk("rst_out_idx", 32'(out_idx), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_frame_done", 32'(frame_done), 32'd0);

        ap_rst_n = 1'b1;
        tick();

        // Bank configuration: bank[i] = 0x0100*i
        for (int i = 0; i < N; i++) begin
            cfg_we      = 1'b1;
            cfg_addr    = 3'(i);
            cfg_wdata   = 16'(16'h0100 * i);
            exp_bank[i] = 16'(16'h0100 * i);
            tick();
        end
        cfg_we = 1'b0;
        #1;
        chk("cfg_idle_bias0", 32'(bias_out), 32'h0000);

        // Inference pass
        run_pass(1'b0, 32'h0010, 32'h0000, -1, -1, -1);
        // Training pass: biases read 0x0100*i, write back 0xFF00-i
        run_pass(1'b1, 32'h0010, 32'hFF00, -1, -1, -1);
        // Backpressure after first accept; reads the trained biases
        run_pass(1'b0, 32'h0010, 32'h0000, 0, -1, -1);
        // start and cfg_we pulsed mid-run must be ignored
        run_pass(1'b0, 32'h0040, 32'h0000, -1, 3, -1);
        // Clock-enable freeze; bank[2] still 0xFEFE
        run_pass(1'b0, 32'h0050, 32'h0000, -1, -1, 5);

        // Reset in the middle of a training pass
        start    = 1'b1;
        training = 1'b1;
        tick();
        start    = 1'b0;
        training = 1'b0;
        for (int i = 0; i < 4; i++) begin
            in_valid       = 1'b1;
            in_net_sum     = 16'(16'h0070 + i);
            in_bias_change = 16'h1234;
            out_ready      = 1'b1;
            tick();
        end
        chk("pre_rst_idx", 32'(idx_out), 32'd4);
        ap_rst_n = 1'b0;
        #1;
        chk("mid_rst_in_ready", 32'(in_ready), 32'd0);
        chk("mid_rst_bias_out", 32'(bias_out), 32'd0);
        chk("mid_rst_idx_out", 32'(idx_out), 32'd0);
        chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_out_net_sum", 32'(out_net_sum), 32'd0);
        chk("mid_rst_out_idx", 32'(out_idx), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_frame_done", 32'(frame_done), 32'd0);
        in_valid = 1'b0;
        tick();
        ap_rst_n = 1'b1;
        for (int i = 0; i < N; i++) exp_bank[i] = '0;
        repeat (10) begin
            tick();
            chk("post_rst_no_done", 32'(frame_done), 32'd0);
        end
        // Bank must read back all zeros after reset
        run_pass(1'b0, 32'h0060, 32'h0000, -1, -1, -1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
